// File: rtl/nco_sched_pkg.sv
// Shared types and constants for the NCO slot scheduler.
// Optional frame counter in nco_sched is enabled by NCO_SCHED_FRAME_CNT_EN.
package nco_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } nco_sched_state_t;

  localparam int NCO_DEF_VOICES      = 8;
  localparam int NCO_DEF_V_OSC       = 4;
  localparam int NCO_SLOTS_PER_FRAME = NCO_DEF_VOICES * NCO_DEF_V_OSC;

  localparam int NCO_FRAME_CNT_W = 16;

endpackage

// File: rtl/nco_slot_cnt.sv
// Voice/oscillator slot counter: ox advances fastest, vx on ox wrap; flags the last slot of a frame.
module nco_slot_cnt #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic               sCLK_XVXOSC,
  input  logic               reset_reg,
  input  logic               en,
  output logic [V_WIDTH-1:0] vx,
  output logic [O_WIDTH-1:0] ox,
  output logic               last
);

  localparam logic [V_WIDTH-1:0] VX_MAX = V_WIDTH'(VOICES - 1);
  localparam logic [O_WIDTH-1:0] OX_MAX = O_WIDTH'(V_OSC - 1);

  assign last = (vx == VX_MAX) && (ox == OX_MAX);

  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      vx <= '0;
      ox <= '0;
    end else if (en) begin
      if (ox == OX_MAX) begin
        ox <= '0;
        vx <= (vx == VX_MAX) ? '0 : vx + 1'b1;
      end else begin
        ox <= ox + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nco_sched.sv
// NCO slot scheduler with frame-aligned phase-zero request handling.
// Define NCO_SCHED_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module nco_sched
  import nco_sched_pkg::*;
#(
  parameter int VOICES  = NCO_DEF_VOICES,
  parameter int V_OSC   = NCO_DEF_V_OSC,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic               sCLK_XVXOSC,
  input  logic               reset_reg,
  input  logic               run,
  input  logic               zero_req,
  input  logic [V_WIDTH-1:0] zero_voice,
  output logic               zero_ack,
  output logic [V_WIDTH-1:0] vx,
  output logic [O_WIDTH-1:0] ox,
  output logic               frame_start,
  output logic [VOICES-1:0]  osc_accum_zero,
  output logic               busy
`ifdef NCO_SCHED_FRAME_CNT_EN
  ,
  output logic [NCO_FRAME_CNT_W-1:0] frame_cnt
`endif
);

  nco_sched_state_t state, state_nxt;

  logic              slot_last;
  logic              cnt_en;
  logic              accept;
  logic              load;
  logic              to_idle;
  logic [VOICES-1:0] pending;
  logic [VOICES-1:0] pending_nxt;

  function automatic logic [VOICES-1:0] voice_bit(input logic [V_WIDTH-1:0] v);
    logic [VOICES-1:0] b;
    b    = '0;
    b[v] = 1'b1;
    return b;
  endfunction

  // The counter only moves while a frame is in flight; leaving a frame wraps it back to (0,0).
  assign cnt_en = (state != IDLE);

  nco_slot_cnt #(
    .VOICES (VOICES),
    .V_OSC  (V_OSC),
    .V_WIDTH(V_WIDTH),
    .O_WIDTH(O_WIDTH)
  ) u_slot_cnt (
    .sCLK_XVXOSC(sCLK_XVXOSC),
    .reset_reg  (reset_reg),
    .en         (cnt_en),
    .vx         (vx),
    .ox         (ox),
    .last       (slot_last)
  );

  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) state <= IDLE;
    else           state <= state_nxt;
  end

  // load marks the edge that starts a frame; to_idle marks the edge that ends the last one.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    to_idle   = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN, STOP: begin
        if (slot_last) begin
          if (run) begin
            state_nxt = RUN;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
            to_idle   = 1'b1;
          end
        end else begin
          state_nxt = run ? RUN : STOP;
        end
      end
      default: begin
        state_nxt = IDLE;
        to_idle   = 1'b1;
      end
    endcase
  end

  assign accept = zero_req & ~zero_ack;

  // A request landing on a frame-load edge joins the fresh pending set, not the mask being loaded.
  always_comb begin
    pending_nxt = load ? '0 : pending;
    if (accept) pending_nxt = pending_nxt | voice_bit(zero_voice);
  end

  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      pending        <= '0;
      zero_ack       <= 1'b0;
      frame_start    <= 1'b0;
      busy           <= 1'b0;
      osc_accum_zero <= '0;
    end else begin
      pending     <= pending_nxt;
      zero_ack    <= accept;
      frame_start <= load;
      busy        <= (state_nxt != IDLE);
      if (load)         osc_accum_zero <= pending;
      else if (to_idle) osc_accum_zero <= '0;
    end
  end

`ifdef NCO_SCHED_FRAME_CNT_EN
  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg)  frame_cnt <= '0;
    else if (load)  frame_cnt <= frame_cnt + 1'b1;
  end
`endif

endmodule
